dup_range_arbiter: RTL and testbench

- Shares one range-generator instance between two requesters (A, B). The generator has the dup_range interface: start pulse with base/limit/step, valid/ready output stream, done level.
- Arbitrates round-robin and launches the granted job with a one-cycle start pulse.
- Routes the generator's output stream and done status back to the owner only.
- Sits between two generator-calling FSMs and a single generator, so duplicate generator hardware is not needed.

---
 rtl/dup_range_arbiter.sv | 135 +++++++++++++
 tb/tb_dup_range_arbiter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/dup_range_arbiter.sv
// Round-robin share of one range generator between requesters A and B; start sampled at edge T, grant/gen_start during T+1.
// Output stream is a zero-latency pass-through to the owner; owner ready drives gen_ready, non-owner sees valid=0/done=1.
module dup_range_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic                    _clock,
    input  logic                    _reset,

    input  logic                    a_start,
    input  logic signed [WIDTH-1:0] a_base,
    input  logic signed [WIDTH-1:0] a_limit,
    input  logic signed [WIDTH-1:0] a_step,
    input  logic                    a_ready,
    output logic                    a_grant,
    output logic                    a_valid,
    output logic                    a_done,
    output logic signed [WIDTH-1:0] a_0,

    input  logic                    b_start,
    input  logic signed [WIDTH-1:0] b_base,
    input  logic signed [WIDTH-1:0] b_limit,
    input  logic signed [WIDTH-1:0] b_step,
    input  logic                    b_ready,
    output logic                    b_grant,
    output logic                    b_valid,
    output logic                    b_done,
    output logic signed [WIDTH-1:0] b_0,

    output logic                    gen_start,
    output logic signed [WIDTH-1:0] gen_base,
    output logic signed [WIDTH-1:0] gen_limit,
    output logic signed [WIDTH-1:0] gen_step,
    output logic                    gen_ready,
    input  logic                    gen_valid,
    input  logic                    gen_done,
    input  logic signed [WIDTH-1:0] gen_0
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        RUN    = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic                    owner_q, owner_d;
    logic                    last_q, last_d;
    logic                    gen_start_q, gen_start_d;
    logic signed [WIDTH-1:0] base_q, base_d;
    logic signed [WIDTH-1:0] limit_q, limit_d;
    logic signed [WIDTH-1:0] step_q, step_d;

    logic pick;
    logic own_ready;
    logic in_launch;
    logic in_run;

    always_ff @(posedge _clock or posedge _reset) begin
        if (_reset) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            last_q      <= 1'b1;
            gen_start_q <= 1'b0;
            base_q      <= '0;
            limit_q     <= '0;
            step_q      <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            gen_start_q <= gen_start_d;
            base_q      <= base_d;
            limit_q     <= limit_d;
            step_q      <= step_d;
        end
    end

    // On a tie the requester that was not served last wins.
    assign pick      = (a_start && b_start) ? ~last_q : b_start;
    assign own_ready = owner_q ? b_ready : a_ready;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        gen_start_d = 1'b0;
        base_d      = base_q;
        limit_d     = limit_q;
        step_d      = step_q;
        case (state_q)
            IDLE: begin
                if (a_start || b_start) begin
                    owner_d     = pick;
                    base_d      = pick ? b_base  : a_base;
                    limit_d     = pick ? b_limit : a_limit;
                    step_d      = pick ? b_step  : a_step;
                    gen_start_d = 1'b1;
                    state_d     = LAUNCH;
                end
            end
            LAUNCH: begin
                state_d = RUN;
            end
            RUN: begin
                // A value presented alongside done must be accepted before leaving.
                if (gen_done && (!gen_valid || own_ready)) begin
                    state_d = IDLE;
                    last_d  = owner_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign in_launch = (state_q == LAUNCH);
    assign in_run    = (state_q == RUN);

    assign gen_start = gen_start_q;
    assign gen_base  = base_q;
    assign gen_limit = limit_q;
    assign gen_step  = step_q;
    assign gen_ready = in_run && own_ready;

    assign a_grant = in_launch && !owner_q;
    assign b_grant = in_launch &&  owner_q;
    assign a_valid = in_run && !owner_q && gen_valid;
    assign b_valid = in_run &&  owner_q && gen_valid;
    assign a_done  = (state_q == IDLE) ||  owner_q || (in_run && gen_done);
    assign b_done  = (state_q == IDLE) || !owner_q || (in_run && gen_done);
    assign a_0     = gen_0;
    assign b_0     = gen_0;

endmodule

// File: tb/tb_dup_range_arbiter.sv
// Directed bench for dup_range_arbiter with a behavioural range generator behind it.
module tb_dup_range_arbiter;

    logic clk;
    logic rst;

    logic               a_start, a_ready, a_grant, a_valid, a_done;
    logic signed [31:0] a_base, a_limit, a_step, a_0;
    logic               b_start, b_ready, b_grant, b_valid, b_done;
    logic signed [31:0] b_base, b_limit, b_step, b_0;
    logic               gen_start, gen_ready, gen_valid, gen_done;
    logic signed [31:0] gen_base, gen_limit, gen_step, gen_0;

    dup_range_arbiter #(.WIDTH(32)) dut (
        ._clock(clk), ._reset(rst),
        .a_start(a_start), .a_base(a_base), .a_limit(a_limit), .a_step(a_step),
        .a_ready(a_ready), .a_grant(a_grant), .a_valid(a_valid), .a_done(a_done), .a_0(a_0),
        .b_start(b_start), .b_base(b_base), .b_limit(b_limit), .b_step(b_step),
        .b_ready(b_ready), .b_grant(b_grant), .b_valid(b_valid), .b_done(b_done), .b_0(b_0),
        .gen_start(gen_start), .gen_base(gen_base), .gen_limit(gen_limit), .gen_step(gen_step),
        .gen_ready(gen_ready), .gen_valid(gen_valid), .gen_done(gen_done), .gen_0(gen_0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Range generator: emits base, base+step, ... while below limit; done is a level.
    logic               g_busy;
    logic signed [31:0] g_cur, g_lim, g_step;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            g_busy <= 1'b0;
            g_cur  <= '0;
            g_lim  <= '0;
            g_step <= '0;
        end else if (gen_start) begin
            g_busy <= 1'b1;
            g_cur  <= gen_base;
            g_lim  <= gen_limit;
            g_step <= gen_step;
        end else if (gen_valid && gen_ready) begin
            g_cur <= g_cur + g_step;
        end
    end
    assign gen_valid = g_busy && (g_cur < g_lim);
    assign gen_done  = !g_busy || (g_cur >= g_lim);
    assign gen_0     = g_cur;

    int total = 0;
    int bad   = 0;
    int cyc_n = 0;
    int a_gnt_n = 0;
    int b_bad = 0;
    int mir_bad = 0;
    int gr_hi = 0;
    bit watch_b = 0;
    bit mirror = 0;
    bit tog = 0;
    logic signed [31:0] a_got[$];
    logic signed [31:0] b_got[$];
    int gnt_who[$];
    int gnt_cyc[$];

    task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock: drive at posedge+1, observe at posedge+4, react to grants.
    task automatic cyc();
        @(posedge clk);
        #1;
        if (tog) a_ready = ~a_ready;
        #3;
        cyc_n++;
        if (a_valid && a_ready) a_got.push_back(a_0);
        if (b_valid && b_ready) b_got.push_back(b_0);
        if (a_grant) begin a_gnt_n++; gnt_who.push_back(0); gnt_cyc.push_back(cyc_n); a_start = 1'b0; end
        if (b_grant) begin gnt_who.push_back(1); gnt_cyc.push_back(cyc_n); b_start = 1'b0; end
        if (watch_b && (b_valid || !b_done)) b_bad++;
        if (mirror && gen_ready && !a_ready) mir_bad++;
        if (mirror && gen_ready) gr_hi++;
    endtask

    task automatic run_done(input string tag);
        bit fin;
        int n;
        fin = 1'b0;
        n = 0;
        while (!fin && n < 300) begin
            cyc();
            n++;
            fin = a_done && b_done && !a_start && !b_start;
        end
        chk({tag, "_finish"}, fin, 1);
        cyc();
    endtask

    task automatic check_stream(input string tag, input bit which, input int base, input int limit, input int step);
        logic signed [31:0] exp_q[$];
        logic signed [31:0] got_q[$];
        int n;
        for (int v = base; v < limit; v += step) exp_q.push_back(v);
        got_q = which ? b_got : a_got;
        chk({tag, "_count"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) chk({tag, "_val"}, got_q[i], exp_q[i]);
        if (which) b_got.delete(); else a_got.delete();
    endtask

    task automatic set_a(input int base, input int limit, input int step);
        a_base = base; a_limit = limit; a_step = step; a_start = 1'b1;
    endtask

    task automatic set_b(input int base, input int limit, input int step);
        b_base = base; b_limit = limit; b_step = step; b_start = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        a_start = 0; a_base = 0; a_limit = 0; a_step = 0; a_ready = 1;
        b_start = 0; b_base = 0; b_limit = 0; b_step = 0; b_ready = 1;
        #2;
        chk("rst_a_done", a_done, 1);
        chk("rst_b_done", b_done, 1);
        chk("rst_a_valid", a_valid, 0);
        chk("rst_b_valid", b_valid, 0);
        chk("rst_gen_start", gen_start, 0);
        chk("rst_gen_ready", gen_ready, 0);
        chk("rst_grants", {a_grant, b_grant}, 0);
        chk("rst_gen_base", gen_base, 0);
        cyc(); cyc();
        rst = 1'b0;
        cyc();

        // A alone
        watch_b = 1'b1;
        set_a(0, 10, 2);
        cyc();
        chk("t1_grant", a_grant, 1);
        chk("t1_gen_start", gen_start, 1);
        chk("t1_gen_base", gen_base, 0);
        chk("t1_gen_limit", gen_limit, 10);
        chk("t1_gen_step", gen_step, 2);
        run_done("t1");
        watch_b = 1'b0;
        check_stream("t1_a", 0, 0, 10, 2);
        chk("t1_a_grants", a_gnt_n, 1);
        chk("t1_b_quiet", b_bad, 0);
        chk("t1_a_done", a_done, 1);

        // Simultaneous request after reset: A first, B after one IDLE cycle
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        gnt_who.delete(); gnt_cyc.delete();
        set_a(0, 10, 2);
        set_b(3, 9, 3);
        run_done("t2");
        chk("t2_ngrants", gnt_who.size(), 2);
        if (gnt_who.size() >= 2) begin
            chk("t2_first", gnt_who[0], 0);
            chk("t2_second", gnt_who[1], 1);
            chk("t2_gap", gnt_cyc[1] - gnt_cyc[0], 8);
        end
        check_stream("t2_a", 0, 0, 10, 2);
        check_stream("t2_b", 1, 3, 9, 3);

        // A with ready toggling every cycle
        tog = 1'b1;
        mirror = 1'b1;
        set_a(0, 10, 2);
        run_done("t4");
        tog = 1'b0;
        mirror = 1'b0;
        a_ready = 1'b1;
        check_stream("t4_a", 0, 0, 10, 2);
        chk("t4_mirror", mir_bad, 0);
        chk("t4_ready_seen", gr_hi > 0, 1);

        // A served last, both request: B wins with an empty range, then A
        gnt_who.delete(); gnt_cyc.delete();
        set_a(1, 3, 1);
        set_b(5, 5, 1);
        run_done("t5");
        chk("t5_ngrants", gnt_who.size(), 2);
        if (gnt_who.size() >= 2) begin
            chk("t5_first", gnt_who[0], 1);
            chk("t5_second", gnt_who[1], 0);
            chk("t5_gap", gnt_cyc[1] - gnt_cyc[0], 3);
        end
        check_stream("t5_b", 1, 5, 5, 1);
        check_stream("t5_a", 0, 1, 3, 1);

        // Reset in the middle of a stream
        set_a(0, 10, 2);
        for (int i = 0; i < 50 && a_got.size() < 3; i++) cyc();
        check_stream("t6_pre", 0, 0, 5, 2);
        rst = 1'b1;
        #1;
        chk("t6_a_valid", a_valid, 0);
        chk("t6_a_done", a_done, 1);
        chk("t6_gen_start", gen_start, 0);
        chk("t6_gen_ready", gen_ready, 0);
        chk("t6_gen_limit", gen_limit, 0);
        cyc();
        rst = 1'b0;
        set_a(0, 4, 1);
        run_done("t6");
        check_stream("t6_a", 0, 0, 4, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
